// File: rtl/tia_pkg.sv
// Shared constants and helpers for the TIA object position counter.
package tia_pkg;

    localparam int LINE_PIXELS = 160;  // visible color clocks per line
    localparam int HMOVE_STEP  = 4;    // color clocks between HMOVE extra clocks
    localparam int HMOVE_BIAS  = 8;    // added to the signed motion value
    localparam int COPY_NEAR   = 16;
    localparam int COPY_MED    = 32;
    localparam int COPY_WIDE   = 64;

    localparam int POS_W = 8;
    localparam int DIV_W = $clog2(HMOVE_STEP);

    typedef logic [POS_W-1:0] pos_t;
    typedef logic [3:0]       hcount_t;

    // Pending extra-clock count for a signed motion value: -8..+7 maps to 0..15.
    function automatic hcount_t hmove_count(input logic [3:0] m);
        logic [4:0] sum;
        sum = {m[3], m} + 5'(HMOVE_BIAS);
        return sum[3:0];
    endfunction

    // True when p is one of the copy start positions selected by nusiz.
    function automatic logic is_copy_pos(input logic [2:0] nusiz, input pos_t p);
        logic hit;
        hit = 1'b0;
        case (nusiz)
            3'd1:    hit = (p == pos_t'(COPY_NEAR));
            3'd2:    hit = (p == pos_t'(COPY_MED));
            3'd3:    hit = (p == pos_t'(COPY_NEAR)) || (p == pos_t'(COPY_MED));
            3'd4:    hit = (p == pos_t'(COPY_WIDE));
            3'd6:    hit = (p == pos_t'(COPY_MED)) || (p == pos_t'(COPY_WIDE));
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/tia_hmove_extra_clock.sv
// HMOVE extra-clock generator: pending count E, 4-cycle phase divider, busy.
module tia_hmove_extra_clock
    import tia_pkg::*;
(
    input  logic       clk,
    input  logic       r_i,
    input  logic       hmove_i,
    input  logic [3:0] m_i,
    output logic       extra_o,
    output logic       busy_o
);

    hcount_t          e_q, e_d;
    logic [DIV_W-1:0] div_q, div_d;

    assign busy_o  = (e_q != '0);
    // The extra clock fires on the last phase of each step, so the advance
    // lands on the 4th, 8th, ... edge after the hmove edge.
    assign extra_o = busy_o && (div_q == DIV_W'(HMOVE_STEP - 1));

    // Next-state: hmove reloads and restarts the phase; otherwise count down.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        e_d   = e_q;
        div_d = div_q;
        if (hmove_i) begin
            e_d   = hmove_count(m_i);
            div_d = '0;
        end else if (busy_o) begin
            div_d = extra_o ? '0 : DIV_W'(div_q + 1'b1);
            if (extra_o) begin
                e_d = e_q - 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (r_i) begin
            e_q   <= '0;
            div_q <= '0;
        end else begin
            e_q   <= e_d;
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/tia_object_position_counter.sv
// TIA object horizontal position counter with HMOVE extra clocks.
// Optional macro TIA_OBJECT_COPIES_EN adds start pulses at nusiz copy positions.
module tia_object_position_counter
    import tia_pkg::*;
(
    input  logic       clk,
    input  logic       r,
    input  logic       motck,
    input  logic       resp,
    input  logic       hmove,
    input  logic       hm_wr,
    input  logic [3:0] hm_d,
    input  logic       hmclr,
    input  logic [2:0] nusiz,
    output logic       start,
    output logic [7:0] pos,
    output logic       busy
);

    logic [3:0] m_q, m_d;
    pos_t       pos_q, pos_d;
    logic       start_q, start_d;
    logic       extra;
    logic       advance;
    pos_t       pos_inc;
    logic       copy_hit;

    tia_hmove_extra_clock u_hmove (
        .clk     (clk),
        .r_i     (r),
        .hmove_i (hmove),
        .m_i     (m_q),
        .extra_o (extra),
        .busy_o  (busy)
    );

    // motck and an extra clock in the same cycle still give a single step.
    assign advance = motck | extra;
    assign pos_inc = (pos_q == pos_t'(LINE_PIXELS - 1)) ? '0 : pos_t'(pos_q + 1'b1);

`ifdef TIA_OBJECT_COPIES_EN
    assign copy_hit = is_copy_pos(nusiz, pos_inc);
`else
    logic unused_nusiz;
    assign unused_nusiz = ^nusiz;
    assign copy_hit     = 1'b0;
`endif

    // Motion register: clear beats write.
    always_comb begin
        m_d = m_q;
        if (hmclr) begin
            m_d = '0;
        end else if (hm_wr) begin
            m_d = hm_d;
        end
    end

    // Position: resp beats advance; start marks a wrap (or copy) landing.
    always_comb begin
        pos_d   = pos_q;
        start_d = 1'b0;
        if (resp) begin
            pos_d = '0;
        end else if (advance) begin
            pos_d   = pos_inc;
            start_d = (pos_inc == '0) || copy_hit;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (r) begin
            m_q     <= '0;
            pos_q   <= '0;
            start_q <= 1'b0;
        end else begin
            m_q     <= m_d;
            pos_q   <= pos_d;
            start_q <= start_d;
        end
    end

    assign pos   = pos_q;
    assign start = start_q;

endmodule

// File: tb/tb_tia_object_position_counter.sv
// Directed self-checking bench for tia_object_position_counter.
module tb_tia_object_position_counter;

    logic       clk;
    logic       r;
    logic       motck;
    logic       resp;
    logic       hmove;
    logic       hm_wr;
    logic [3:0] hm_d;
    logic       hmclr;
    logic [2:0] nusiz;
    logic       start;
    logic [7:0] pos;
    logic       busy;

    int n_vec;
    int n_err;

`ifdef TIA_OBJECT_COPIES_EN
    localparam bit COPIES = 1'b1;
`else
    localparam bit COPIES = 1'b0;
`endif

    tia_object_position_counter dut (
        .clk   (clk),
        .r     (r),
        .motck (motck),
        .resp  (resp),
        .hmove (hmove),
        .hm_wr (hm_wr),
        .hm_d  (hm_d),
        .hmclr (hmclr),
        .nusiz (nusiz),
        .start (start),
        .pos   (pos),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_m(input logic [3:0] v);
        hm_wr = 1'b1;
        hm_d  = v;
        tick();
        hm_wr = 1'b0;
    endtask

    task automatic pulse_hmove();
        hmove = 1'b1;
        tick();
        hmove = 1'b0;
    endtask

    task automatic zero_pos();
        resp = 1'b1;
        tick();
        resp = 1'b0;
    endtask

    task automatic test_reset();
        r = 1'b1; motck = 1'b1; resp = 1'b0; hmove = 1'b1;
        hm_wr = 1'b1; hm_d = 4'h7; hmclr = 1'b0; nusiz = 3'd0;
        tick();
        tick();
        hmove = 1'b0; hm_wr = 1'b0; motck = 1'b0;
        tick();
        n_vec++;
        if (pos !== 8'd0) begin n_err++; $display("FAIL reset_pos: got %0d want 0", pos); end
        n_vec++;
        if (start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", start); end
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    // Full line from reset: 1..159 then 0, start on the wrap (plus copies if built in).
    task automatic test_line();
        int exp_pos;
        logic exp_start;
        nusiz = 3'd6;
        r     = 1'b0;
        motck = 1'b1;
        for (int i = 1; i <= 160; i++) begin
            tick();
            exp_pos   = i % 160;
            exp_start = (exp_pos == 0) || (COPIES && (exp_pos == 32 || exp_pos == 64));
            n_vec++;
            if (pos !== 8'(exp_pos)) begin
                n_err++; $display("FAIL line_pos[%0d]: got %0d want %0d", i, pos, exp_pos);
            end
            n_vec++;
            if (start !== exp_start) begin
                n_err++; $display("FAIL line_start[%0d]: got %b want %b", i, start, exp_start);
            end
        end
        motck = 1'b0;
        nusiz = 3'd0;
    endtask

    task automatic test_resp();
        motck = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        n_vec++;
        if (pos !== 8'd100) begin n_err++; $display("FAIL resp_pre: got %0d want 100", pos); end
        resp = 1'b1;
        tick();
        resp = 1'b0;
        n_vec++;
        if (pos !== 8'd0) begin n_err++; $display("FAIL resp_pos: got %0d want 0", pos); end
        n_vec++;
        if (start !== 1'b0) begin n_err++; $display("FAIL resp_start: got %b want 0", start); end
        tick();
        n_vec++;
        if (pos !== 8'd1) begin n_err++; $display("FAIL resp_next: got %0d want 1", pos); end
        // resp at 159 with an advance must not produce a wrap start
        for (int i = 0; i < 158; i++) tick();
        n_vec++;
        if (pos !== 8'd159) begin n_err++; $display("FAIL resp_159_pre: got %0d want 159", pos); end
        resp = 1'b1;
        tick();
        resp = 1'b0;
        n_vec++;
        if (pos !== 8'd0) begin n_err++; $display("FAIL resp_159_pos: got %0d want 0", pos); end
        n_vec++;
        if (start !== 1'b0) begin n_err++; $display("FAIL resp_159_start: got %b want 0", start); end
        motck = 1'b0;
    endtask

    task automatic test_hmove_max();
        int exp_pos;
        zero_pos();
        write_m(4'h7);
        pulse_hmove();
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL hmax_busy0: got %b want 1", busy); end
        for (int k = 1; k <= 68; k++) begin
            tick();
            exp_pos = (k / 4 > 15) ? 15 : k / 4;
            n_vec++;
            if (pos !== 8'(exp_pos)) begin
                n_err++; $display("FAIL hmax_pos[%0d]: got %0d want %0d", k, pos, exp_pos);
            end
            n_vec++;
            if (busy !== (k < 60)) begin
                n_err++; $display("FAIL hmax_busy[%0d]: got %b want %b", k, busy, (k < 60));
            end
        end
    endtask

    task automatic test_hmove_min();
        int exp_pos;
        zero_pos();
        write_m(4'h8);
        pulse_hmove();
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_vec++;
            if (pos !== 8'd0 || busy !== 1'b0) begin
                n_err++; $display("FAIL hmin[%0d]: got pos=%0d busy=%b want pos=0 busy=0", k, pos, busy);
            end
        end
        // clear beats write: m ends at 0, giving 8 extras
        hm_wr = 1'b1; hm_d = 4'h3; hmclr = 1'b1;
        tick();
        hm_wr = 1'b0; hmclr = 1'b0;
        pulse_hmove();
        for (int k = 1; k <= 36; k++) begin
            tick();
            exp_pos = (k / 4 > 8) ? 8 : k / 4;
            n_vec++;
            if (pos !== 8'(exp_pos) || busy !== (k < 32)) begin
                n_err++;
                $display("FAIL hclr[%0d]: got pos=%0d busy=%b want pos=%0d busy=%b", k, pos, busy, exp_pos, (k < 32));
            end
        end
    endtask

    task automatic test_back_to_back();
        int exp_pos;
        zero_pos();
        pulse_hmove();
        for (int k = 1; k <= 9; k++) tick();
        pulse_hmove();
        n_vec++;
        if (pos !== 8'd2 || busy !== 1'b1) begin
            n_err++; $display("FAIL b2b_restart: got pos=%0d busy=%b want pos=2 busy=1", pos, busy);
        end
        for (int k = 1; k <= 36; k++) begin
            tick();
            exp_pos = 2 + ((k / 4 > 8) ? 8 : k / 4);
            n_vec++;
            if (pos !== 8'(exp_pos) || busy !== (k < 32)) begin
                n_err++;
                $display("FAIL b2b[%0d]: got pos=%0d busy=%b want pos=%0d busy=%b", k, pos, busy, exp_pos, (k < 32));
            end
        end
    endtask

    // motck held high during HMOVE: coinciding extra clocks add nothing.
    task automatic test_or_semantics();
        zero_pos();
        pulse_hmove();
        motck = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            n_vec++;
            if (pos !== 8'(k)) begin
                n_err++; $display("FAIL or_pos[%0d]: got %0d want %0d", k, pos, k);
            end
        end
        motck = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL or_busy: got %b want 0", busy); end
    endtask

    task automatic test_resp_during_hmove();
        int exp_pos;
        zero_pos();
        pulse_hmove();
        for (int k = 1; k <= 5; k++) tick();
        zero_pos();
        n_vec++;
        if (pos !== 8'd0 || busy !== 1'b1) begin
            n_err++; $display("FAIL rdh_resp: got pos=%0d busy=%b want pos=0 busy=1", pos, busy);
        end
        for (int k = 7; k <= 40; k++) begin
            tick();
            exp_pos = ((k / 4 > 8) ? 8 : k / 4) - 1;
            n_vec++;
            if (pos !== 8'(exp_pos) || busy !== (k < 32)) begin
                n_err++;
                $display("FAIL rdh[%0d]: got pos=%0d busy=%b want pos=%0d busy=%b", k, pos, busy, exp_pos, (k < 32));
            end
        end
    endtask

    task automatic test_reset_mid_hmove();
        write_m(4'h7);
        zero_pos();
        pulse_hmove();
        for (int k = 1; k <= 5; k++) tick();
        r = 1'b1;
        tick();
        r = 1'b0;
        n_vec++;
        if (pos !== 8'd0 || busy !== 1'b0 || start !== 1'b0) begin
            n_err++; $display("FAIL rmh_reset: got pos=%0d busy=%b start=%b want 0/0/0", pos, busy, start);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_vec++;
            if (pos !== 8'd0 || busy !== 1'b0) begin
                n_err++; $display("FAIL rmh_abort[%0d]: got pos=%0d busy=%b want 0/0", k, pos, busy);
            end
        end
        // reset also cleared m, so the next hmove gives 8 extras
        pulse_hmove();
        for (int k = 1; k <= 36; k++) tick();
        n_vec++;
        if (pos !== 8'd8 || busy !== 1'b0) begin
            n_err++; $display("FAIL rmh_m_cleared: got pos=%0d busy=%b want pos=8 busy=0", pos, busy);
        end
        motck = 1'b1;
        tick();
        motck = 1'b0;
        n_vec++;
        if (pos !== 8'd9) begin n_err++; $display("FAIL rmh_after: got %0d want 9", pos); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_line();
        test_resp();
        test_hmove_max();
        test_hmove_min();
        test_back_to_back();
        test_or_semantics();
        test_resp_during_hmove();
        test_reset_mid_hmove();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tia_object_position_counter.md
TIA_OBJECT_POSITION_COUNTER -- requirements
Module: tia_object_position_counter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all other ports are listed below.
REQ-002 clk  in  1  color clock; the only clock; all state changes on its rising edge.
REQ-003 r  in  1  reset, synchronous, active-high.
REQ-004 motck  in  1  object count enable from horizontal timing; one pulse per visible color clock.
REQ-005 resp  in  1  reset-position strobe, one clk wide.
REQ-006 hmove  in  1  HMOVE strobe, one clk wide.
REQ-007 hm_wr  in  1  motion-register write strobe.
REQ-008 hm_d  in  4  motion value, two's complement, range -8..+7.
REQ-009 hmclr  in  1  clears the motion register.
REQ-010 nusiz  in  3  copy/spacing select; ignored unless the copy feature is compiled in.
REQ-011 start  out  1  draw-start pulse, one clk wide.
REQ-012 pos  out  8  current position, range 0..159.
REQ-013 busy  out  1  high while HMOVE extra clocks are still pending.

Function
REQ-014 An advance SHALL occur in any cycle where motck or an extra clock is high; both together SHALL give one advance, not two (OR semantics).
REQ-015 An advance SHALL step pos from 159 to 0 and otherwise add 1; pos SHALL never exceed 159.
REQ-016 start SHALL be high for exactly the one cycle in which pos becomes 0 through an advance from 159.
REQ-017 resp SHALL set pos to 0 on the next edge without asserting start; resp SHALL win over a same-cycle advance.
REQ-018 hm_wr SHALL load hm_d into the motion register m; hmclr SHALL set m to 0; hmclr SHALL win over a same-cycle hm_wr.
REQ-019 hmove SHALL load a pending count E = m + 8 (0..15), using the m value in effect before that edge.
REQ-020 Extra clocks SHALL occur on the 4th, 8th, 12th, ... clk after the hmove edge; each one SHALL decrement E, until E = 0.
REQ-021 busy SHALL equal (E != 0); if m = -8, busy SHALL not assert.
REQ-022 An hmove arriving while busy SHALL restart the sequence: E is reloaded and the 4-cycle phase restarts.
REQ-023 resp during HMOVE SHALL zero pos; the pending extra clocks SHALL continue.

Reset
REQ-024 While r is high: pos = 0, start = 0, busy = 0, E = 0, m = 0, phase divider = 0.
REQ-025 r SHALL take priority over every other input, and r mid-HMOVE SHALL abort the sequence.
REQ-026 The first advance after r deasserts SHALL give pos = 1.

Configuration
REQ-027 With TIA_OBJECT_COPIES_EN defined, start SHALL also pulse when an advance lands on a copy position selected by nusiz.
REQ-028 Copy positions by nusiz: 0 none, 1 {16}, 2 {32}, 3 {16,32}, 4 {64}, 5 none, 6 {32,64}, 7 none.
REQ-029 Without TIA_OBJECT_COPIES_EN, nusiz SHALL be unused and start SHALL pulse only on wrap.

Structure
REQ-030 Constants SHALL live in a shared package tia_pkg: LINE_PIXELS = 160, HMOVE_STEP = 4, HMOVE_BIAS = 8, copy offsets 16/32/64.
REQ-031 The HMOVE extra-clock generator (E counter, 4-cycle divider, busy) SHALL be one sub-module, tia_hmove_extra_clock.

Verification
REQ-032 Release r, hold motck = 1 for 160 clk -> pos steps 1..159 then 0; start high only on the 160th cycle.
REQ-033 pos = 100, assert resp alone with motck = 1 -> next pos = 0 with start = 0; the following advance gives pos = 1.
REQ-034 m = +7, motck = 0, pulse hmove -> 15 extra clocks at cycles 4, 8, ..., 60; pos rises by 15; busy low after cycle 60.
REQ-035 m = -8, pulse hmove -> pos unchanged and busy stays 0; hm_wr = 3 with hmclr in the same cycle -> m = 0, so the next hmove gives 8 extras.
REQ-036 m = 0, hmove, then a second hmove 10 clk later -> 2 extras from the first, then a fresh 8 from the second; total 10.
REQ-037 With TIA_OBJECT_COPIES_EN and nusiz = 6, run a full line -> start pulses at pos 0, 32 and 64 only; without the macro, start pulses at pos 0 only.
